// File: rtl/fmap2_stream_loader.sv
// Streams 50 signed words into a 2x5x5 feature map (column fastest, then row, then channel)
// and holds the map until the consumer acks. Optional macro FMAP_LOADER_RELU_EN clamps negative words to 0.
//
// state | meaning
// LOAD  | accepting words, in_ready=1, fmap_valid=0
// FULL  | complete frame held stable, in_ready=0, fmap_valid=1

module fmap2_stream_loader #(
   parameter int bitwidth = 16
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic signed [bitwidth-1:0]                  in_data,
   input  logic                                        in_valid,
   output logic                                        in_ready,
   input  logic                                        in_last,
   output logic signed [1:0][4:0][4:0][bitwidth-1:0]   featuremap2,
   output logic                                        fmap_valid,
   input  logic                                        fmap_ack,
   output logic                                        frame_error
);

   typedef enum logic {LOAD = 1'b0, FULL = 1'b1} state_t;

   state_t                              state_q, state_d;
   logic                                ch_q, ch_d;
   logic [2:0]                          row_q, row_d;
   logic [2:0]                          col_q, col_d;
   logic                                frame_error_q, frame_error_d;
   logic [1:0][4:0][4:0][bitwidth-1:0]  fmap_q, fmap_d;
   logic [bitwidth-1:0]                 word;
   logic                                hs;
   logic                                last_word;

   always_comb begin
`ifdef FMAP_LOADER_RELU_EN
      word = in_data[bitwidth-1] ? '0 : in_data;
`else
      word = in_data;
`endif
   end

   always_comb begin
      state_d       = state_q;
      ch_d          = ch_q;
      row_d         = row_q;
      col_d         = col_q;
      fmap_d        = fmap_q;
      frame_error_d = 1'b0;
      hs            = (state_q == LOAD) && in_valid;
      last_word     = ch_q && (row_q == 3'd4) && (col_q == 3'd4);

      if (state_q == LOAD) begin
         if (hs) begin
            fmap_d[ch_q][row_q][col_q] = word;
            if (last_word) begin
               state_d       = FULL;
               ch_d          = 1'b0;
               row_d         = 3'd0;
               col_d         = 3'd0;
               frame_error_d = ~in_last;
            end else if (in_last) begin
               // Early in_last: drop the partial frame but keep whatever was already written.
               ch_d          = 1'b0;
               row_d         = 3'd0;
               col_d         = 3'd0;
               frame_error_d = 1'b1;
            end else if (col_q == 3'd4) begin
               col_d = 3'd0;
               if (row_q == 3'd4) begin
                  row_d = 3'd0;
                  ch_d  = 1'b1;
               end else begin
                  row_d = row_q + 3'd1;
               end
            end else begin
               col_d = col_q + 3'd1;
            end
         end
      end else if (fmap_ack) begin
         state_d = LOAD;
         ch_d    = 1'b0;
         row_d   = 3'd0;
         col_d   = 3'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= LOAD;
         ch_q          <= 1'b0;
         row_q         <= 3'd0;
         col_q         <= 3'd0;
         frame_error_q <= 1'b0;
         fmap_q        <= '0;
      end else begin
         state_q       <= state_d;
         ch_q          <= ch_d;
         row_q         <= row_d;
         col_q         <= col_d;
         frame_error_q <= frame_error_d;
         fmap_q        <= fmap_d;
      end
   end

   assign in_ready    = (state_q == LOAD);
   assign fmap_valid  = (state_q == FULL);
   assign frame_error = frame_error_q;
   assign featuremap2 = fmap_q;

endmodule

// File: tb/tb_fmap2_stream_loader.sv
// Self-checking bench for fmap2_stream_loader: directed frames plus randomized traffic
// compared every cycle against a flat-array reference model.

module tb_fmap2_stream_loader;

   localparam int BW = 16;

   logic                                 clk;
   logic                                 rst;
   logic signed [BW-1:0]                 in_data;
   logic                                 in_valid;
   logic                                 in_ready;
   logic                                 in_last;
   logic signed [1:0][4:0][4:0][BW-1:0]  featuremap2;
   logic                                 fmap_valid;
   logic                                 fmap_ack;
   logic                                 frame_error;

   fmap2_stream_loader #(.bitwidth(BW)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_last     (in_last),
      .featuremap2 (featuremap2),
      .fmap_valid  (fmap_valid),
      .fmap_ack    (fmap_ack),
      .frame_error (frame_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: frame position k, full flag, error pulse, map stored flat by k.
   logic [BW-1:0] ref_map [50];
   int            ref_k;
   logic          ref_full;
   logic          ref_err;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [BW-1:0] store_val(input logic [BW-1:0] d);
`ifdef FMAP_LOADER_RELU_EN
      return d[BW-1] ? '0 : d;
`else
      return d;
`endif
   endfunction

   task automatic model_edge();
      if (rst) begin
         ref_full = 1'b0;
         ref_k    = 0;
         ref_err  = 1'b0;
         for (int i = 0; i < 50; i++) ref_map[i] = '0;
      end else if (!ref_full) begin
         ref_err = 1'b0;
         if (in_valid) begin
            ref_map[ref_k] = store_val(in_data);
            if (ref_k == 49) begin
               ref_full = 1'b1;
               ref_k    = 0;
               ref_err  = !in_last;
            end else if (in_last) begin
               ref_k   = 0;
               ref_err = 1'b1;
            end else begin
               ref_k++;
            end
         end
      end else begin
         ref_err = 1'b0;
         if (fmap_ack) ref_full = 1'b0;
      end
   endtask

   task automatic compare_all();
      chk("in_ready", in_ready, !ref_full);
      chk("fmap_valid", fmap_valid, ref_full);
      chk("frame_error", frame_error, ref_err);
      for (int k = 0; k < 50; k++)
         chk($sformatf("map[%0d][%0d][%0d]", k / 25, (k % 25) / 5, k % 5),
             featuremap2[k / 25][(k % 25) / 5][k % 5], ref_map[k]);
   endtask

   task automatic step(input logic r, input logic v, input logic [BW-1:0] d,
                       input logic l, input logic a);
      @(negedge clk);
      rst      = r;
      in_valid = v;
      in_data  = d;
      in_last  = l;
      fmap_ack = a;
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic send_words(input int n, input int base, input bit last_on_final);
      for (int i = 0; i < n; i++)
         step(1'b0, 1'b1, BW'(base + i), (last_on_final && i == n - 1), 1'b0);
   endtask

   initial begin
      logic [BW-1:0] neg5;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; fmap_ack = 1'b0;
      for (int i = 0; i < 50; i++) ref_map[i] = 'x;
      ref_k = 0; ref_full = 1'b0; ref_err = 1'b0;

      step(1'b1, 1'b1, 16'h1234, 1'b1, 1'b1);
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);

      // Full frame 1..50 with in_last on word 50.
      send_words(50, 1, 1'b1);
      chk("full_after_50", fmap_valid, 1'b1);
      chk("m000", featuremap2[0][0][0], 64'd1);
      chk("m044", featuremap2[0][4][4], 64'd25);
      chk("m100", featuremap2[1][0][0], 64'd26);
      chk("m144", featuremap2[1][4][4], 64'd50);

      // Held in FULL despite traffic, then released by ack.
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b0);
      step(1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      chk("ack_ready", in_ready, 1'b1);
      chk("ack_valid", fmap_valid, 1'b0);

      // Early in_last at k=9, then a full frame.
      send_words(10, 100, 1'b1);
      chk("early_err", frame_error, 1'b1);
      step(1'b0, 1'b1, 16'd500, 1'b0, 1'b1);
      chk("restart_m000", featuremap2[0][0][0], 64'd500);
      send_words(49, 501, 1'b1);
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);

      // Frame without in_last: completes with error pulse.
      send_words(50, 200, 1'b0);
      chk("nolast_err", frame_error, 1'b1);
      chk("nolast_valid", fmap_valid, 1'b1);
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);

      // Reset mid-frame, then a fresh frame.
      send_words(30, 300, 1'b0);
      step(1'b1, 1'b1, 16'h5555, 1'b1, 1'b1);
      chk("rst_m000", featuremap2[0][0][0], 64'd0);
      send_words(50, 1000, 1'b1);
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);

      // Negative word at k=0.
      neg5 = 16'hFFFB;
      step(1'b0, 1'b1, neg5, 1'b0, 1'b0);
`ifdef FMAP_LOADER_RELU_EN
      chk("neg5", featuremap2[0][0][0], 64'd0);
`else
      chk("neg5", featuremap2[0][0][0], 64'hFFFB);
`endif

      // Randomized traffic.
      for (int i = 0; i < 1500; i++)
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), BW'($urandom),
              ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
